tdm_demux_8: RTL and testbench

Eight-lane time-division demultiplexer: the receive end of a serial link whose transmitter drives one line from eight data lanes in slot order D0…D7. It aligns to a frame-sync strobe and reassembles each 8-slot frame into a parallel word. It presents the word on `dout` with a one-cycle `frame_valid` pulse. It sits in the unit-design set next to the 8:1 select logic and serves as its loop-back checker in the benchmark flow.

---
 rtl/tdm_pkg.sv | 27 ++
 rtl/tdm_slot_ctr.sv | 29 ++
 rtl/tdm_demux_8.sv | 94 +++++++++
 tb/tb_tdm_demux_8.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and constants for the 8-lane TDM demultiplexer.
// Frame length depends on DEMUX_PARITY_EN (9 slots with a parity slot, otherwise 8).
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } tdm_state_e;

    localparam int TDM_LANES  = 8;
    localparam int TDM_SLOT_W = 3;

`ifdef DEMUX_PARITY_EN
    // The counter needs one extra bit to reach the parity slot (index 8).
    localparam int                    TDM_CNT_W     = TDM_SLOT_W + 1;
    localparam logic [TDM_CNT_W-1:0]  TDM_LAST_SLOT = 4'd8;
`else
    localparam int                    TDM_CNT_W     = TDM_SLOT_W;
    localparam logic [TDM_CNT_W-1:0]  TDM_LAST_SLOT = 3'd7;
`endif

    // Even-parity bit for a data byte: XOR of the byte and this bit is zero.
    function automatic logic even_parity8(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter for the TDM demultiplexer: step with wrap at the last slot, load-to-1 on sync.
// The last slot is 8 when DEMUX_PARITY_EN is defined, 7 otherwise.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 step,
    input  logic                 load,
    output logic [TDM_CNT_W-1:0] cnt,
    output logic                 frame_end
);

    assign frame_end = (cnt == TDM_LAST_SLOT);

    // Slot counter: load has priority so a sync on the last slot restarts the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= {TDM_CNT_W{1'b0}};
        end else if (load) begin
            cnt <= TDM_CNT_W'(1);
        end else if (step) begin
            cnt <= frame_end ? {TDM_CNT_W{1'b0}} : cnt + TDM_CNT_W'(1);
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/tdm_demux_8.sv
// Eight-lane TDM demultiplexer: aligns on sync, reassembles 8-slot frames into dout.
// Optional parity slot and par_err check are enabled by DEMUX_PARITY_EN.
module tdm_demux_8
    import tdm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  din,
    input  logic                  en,
    input  logic                  sync,
    output logic [TDM_LANES-1:0]  dout,
    output logic                  frame_valid,
    output logic [TDM_SLOT_W-1:0] slot,
    output logic                  locked,
    output logic                  sync_err,
    output logic                  par_err
);

    tdm_state_e           state_r;
    logic [TDM_LANES-1:0] shift_r;
    logic [TDM_CNT_W-1:0] cnt_s;
    logic                 frame_end_s;
    logic                 step_s;
    logic                 load_s;

    assign load_s = en & sync;
    assign step_s = en & ~sync & (state_r == RUN);

    tdm_slot_ctr u_slot_ctr (
        .clk       (clk),
        .rst       (rst),
        .step      (step_s),
        .load      (load_s),
        .cnt       (cnt_s),
        .frame_end (frame_end_s)
    );

    // Slot 8 of a parity frame reads back as 0 through the truncation.
    assign slot = cnt_s[TDM_SLOT_W-1:0];

`ifdef DEMUX_PARITY_EN
    logic par_err_r;
    assign par_err = par_err_r;
`else
    assign par_err = 1'b0;
`endif

    // Alignment FSM, frame assembly and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= HUNT;
            shift_r     <= 8'h00;
            dout        <= 8'h00;
            frame_valid <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
`ifdef DEMUX_PARITY_EN
            par_err_r   <= 1'b0;
`endif
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
`ifdef DEMUX_PARITY_EN
            par_err_r   <= 1'b0;
`endif
            if (en && sync) begin
                // Any sync away from slot 0 is a misalignment; the partial frame is dropped.
                state_r  <= RUN;
                locked   <= 1'b1;
                shift_r  <= {7'b0000000, din};
                sync_err <= (state_r == RUN) && (cnt_s != {TDM_CNT_W{1'b0}});
            end else if (en && (state_r == RUN)) begin
                if (frame_end_s) begin
`ifdef DEMUX_PARITY_EN
                    if (even_parity8(shift_r) == din) begin
                        dout        <= shift_r;
                        frame_valid <= 1'b1;
                    end else begin
                        par_err_r   <= 1'b1;
                    end
`else
                    dout        <= {din, shift_r[6:0]};
                    frame_valid <= 1'b1;
`endif
                end else begin
                    shift_r[cnt_s[TDM_SLOT_W-1:0]] <= din;
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_8.sv
// Self-checking bench for tdm_demux_8: directed scenarios plus random traffic against a queue-based model.
module tb_tdm_demux_8;

`ifdef DEMUX_PARITY_EN
    localparam int FLEN = 9;
`else
    localparam int FLEN = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       en = 1'b0;
    logic       sync = 1'b0;
    logic [7:0] dout;
    logic       frame_valid;
    logic [2:0] slot;
    logic       locked;
    logic       sync_err;
    logic       par_err;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state: bits received so far in the current frame.
    bit   q[$];
    bit   m_locked = 1'b0;
    logic [7:0] m_dout = 8'h00;
    bit   m_fv = 1'b0, m_se = 1'b0, m_pe = 1'b0;
    int   n_fv_seen = 0;

    tdm_demux_8 dut (
        .clk(clk), .rst(rst), .din(din), .en(en), .sync(sync),
        .dout(dout), .frame_valid(frame_valid), .slot(slot),
        .locked(locked), .sync_err(sync_err), .par_err(par_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the applied inputs.
    task automatic model_edge(input bit r, input bit e, input bit s, input bit d);
        logic [7:0] word;
        m_fv = 1'b0; m_se = 1'b0; m_pe = 1'b0;
        if (r) begin
            q.delete(); m_locked = 1'b0; m_dout = 8'h00;
        end else if (e) begin
            if (s) begin
                if (m_locked && q.size() != 0) m_se = 1'b1;
                q.delete(); q.push_back(d); m_locked = 1'b1;
            end else if (m_locked) begin
                q.push_back(d);
                if (q.size() == FLEN) begin
                    word = 8'h00;
                    for (int i = 0; i < 8; i++) if (q[i]) word = word + (8'd1 << i);
                    if (FLEN == 9 && ((^word) != q[8])) m_pe = 1'b1;
                    else begin m_dout = word; m_fv = 1'b1; end
                    q.delete();
                end
            end
        end
    endtask

    // Apply inputs, clock once, then compare every output at the falling edge.
    task automatic step(input bit r, input bit e, input bit s, input bit d);
        rst = r; en = e; sync = s; din = d;
        @(posedge clk);
        model_edge(r, e, s, d);
        @(negedge clk);
        if (frame_valid === 1'b1) n_fv_seen++;
        check_val("dout", dout, m_dout);
        check_val("frame_valid", frame_valid, m_fv);
        check_val("slot", slot, q.size() % 8);
        check_val("locked", locked, m_locked);
        check_val("sync_err", sync_err, m_se);
        check_val("par_err", par_err, m_pe);
    endtask

    task automatic send_bits(input logic [7:0] w, input bit first_sync);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, first_sync && i == 0, w[i]);
`ifdef DEMUX_PARITY_EN
        step(1'b0, 1'b1, 1'b0, ^w);
`endif
    endtask

    initial begin
        int fv0;
        logic [7:0] w;
        // Reset for two cycles.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check_val("rst_dout", dout, 8'h00);
        check_val("rst_locked", locked, 1'b0);
        check_val("rst_slot", slot, 3'd0);

        // Lock on first frame: bits 1,0,1,1,0,0,1,0 -> 8'h4D.
        fv0 = n_fv_seen;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check_val("lock_first_bit", locked, 1'b1);
        check_val("slot_after_sync", slot, 3'd1);
        w = 8'h4D;
        for (int i = 1; i < 8; i++) step(1'b0, 1'b1, 1'b0, w[i]);
`ifdef DEMUX_PARITY_EN
        step(1'b0, 1'b1, 1'b0, ^w);
`endif
        check_val("lock_dout", dout, 8'h4D);
        check_val("lock_fv", frame_valid, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("lock_fv_count", n_fv_seen - fv0, 1);

        // Free-run frame 8'hA5 with a 3-cycle gap between bits 3 and 4.
        w = 8'hA5;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, w[i]);
        for (int g = 0; g < 3; g++) begin
            step(1'b0, 1'b0, 1'b0, g[0]);
            check_val("gap_slot_hold", slot, 3'd4);
        end
        for (int i = 4; i < 8; i++) step(1'b0, 1'b1, 1'b0, w[i]);
`ifdef DEMUX_PARITY_EN
        step(1'b0, 1'b1, 1'b0, ^w);
`endif
        check_val("gap_dout", dout, 8'hA5);
        check_val("gap_fv", frame_valid, 1'b1);

        // Misplaced sync after 5 bits, then a full 8'hFF frame.
        fv0 = n_fv_seen;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check_val("resync_err", sync_err, 1'b1);
        check_val("resync_slot", slot, 3'd1);
        for (int i = 1; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
`ifdef DEMUX_PARITY_EN
        step(1'b0, 1'b1, 1'b0, 1'b0);
`endif
        check_val("resync_dout", dout, 8'hFF);
        check_val("resync_fv_count", n_fv_seen - fv0, 1);

        // Sync on the frame-completing bit is misplaced and suppresses delivery.
        for (int i = 0; i < FLEN - 1; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check_val("late_sync_err", sync_err, 1'b1);
        check_val("late_sync_no_fv", frame_valid, 1'b0);
        check_val("late_sync_dout", dout, 8'hFF);

        // Reset mid-frame, then unsynchronised bits are ignored.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check_val("midrst_dout", dout, 8'h00);
        check_val("midrst_locked", locked, 1'b0);
        check_val("midrst_slot", slot, 3'd0);

        // HUNT ignore: 20 enabled cycles with no sync.
        fv0 = n_fv_seen;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
        check_val("hunt_locked", locked, 1'b0);
        check_val("hunt_no_fv", n_fv_seen - fv0, 0);

`ifdef DEMUX_PARITY_EN
        // Good parity frame, then a bad one that must leave dout alone.
        send_bits(8'h03, 1'b1);
        check_val("par_ok_dout", dout, 8'h03);
        check_val("par_ok_fv", frame_valid, 1'b1);
        w = 8'h07;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, w[i]);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_val("par_bad_err", par_err, 1'b1);
        check_val("par_bad_dout", dout, 8'h03);
`else
        send_bits(8'h3C, 1'b1);
        check_val("plain_dout", dout, 8'h3C);
        check_val("par_err_tied", par_err, 1'b0);
`endif

        // Back-to-back frames, no idle cycles.
        send_bits(8'h96, 1'b0);
        check_val("b2b_dout1", dout, 8'h96);
        send_bits(8'h69, 1'b0);
        check_val("b2b_dout2", dout, 8'h69);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 39) == 0,
                 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
